// File: rtl/split_radio_receiver.sv
// Receiver stage behind the radio/wire splitter: deframes both serial lanes,
// pairs and votes their words, and presents the result on a valid/ready port.

module SplitRadioReceiverLane #(
  parameter int DATA_BITS  = 8,
  parameter int BIT_CYCLES = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  input  logic                 releaseLane_i,
  output logic                 done_o,
  output logic [DATA_BITS-1:0] word_o,
  output logic                 frameErr_o
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {LANE_IDLE, LANE_START, LANE_DATA, LANE_STOP, LANE_DONE} laneState_t;

  laneState_t           state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bits_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frameErr_q;

  // Start bit is qualified at its midpoint; later samples stay mid-bit.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= LANE_IDLE;
      cnt_q      <= '0;
      bits_q     <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      case (state_q)
        LANE_IDLE: begin
          if (!rx_i) begin
            state_q <= LANE_START;
            cnt_q   <= '0;
          end
        end
        LANE_START: begin
          if (cnt_q == HALF_BIT) begin
            cnt_q   <= '0;
            bits_q  <= '0;
            state_q <= rx_i ? LANE_IDLE : LANE_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LANE_DATA: begin
          if (cnt_q == FULL_BIT) begin
            cnt_q   <= '0;
            shift_q <= {rx_i, shift_q[DATA_BITS-1:1]};
            bits_q  <= bits_q + 1'b1;
            if (bits_q == LAST_BIT) state_q <= LANE_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LANE_STOP: begin
          if (cnt_q == FULL_BIT) begin
            cnt_q <= '0;
            if (rx_i) begin
              state_q <= LANE_DONE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= LANE_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LANE_DONE: begin
          if (releaseLane_i) state_q <= LANE_IDLE;
        end
        default: state_q <= LANE_IDLE;
      endcase
    end
  end

  assign done_o     = (state_q == LANE_DONE);
  assign word_o     = shift_q;
  assign frameErr_o = frameErr_q;
endmodule

module split_radio_receiver #(
  parameter int DATA_BITS    = 8,
  parameter int BIT_CYCLES   = 16,
  parameter int SKEW_MAX     = 32,
  parameter int PREFER_RADIO = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ReceivedRadio,
  input  logic                 ReceivedWire,
  output logic [DATA_BITS-1:0] Data,
  output logic                 DataValid,
  input  logic                 DataReady,
  output logic [1:0]           Source,
  output logic                 Mismatch,
  output logic [1:0]           FrameError,
  output logic                 Overrun
);
  localparam int SW = $clog2(SKEW_MAX + 1);
  localparam logic [SW-1:0] SKEW_LAST = SW'(SKEW_MAX - 1);

  typedef enum logic [1:0] {COMB_WAIT, COMB_PAIR, COMB_EMIT} combState_t;

  logic [1:0] radioSync_q, wireSync_q;
  logic radioDone, wireDone, radioErr, wireErr, releaseRadio, releaseWire;
  logic [DATA_BITS-1:0] radioWord, wireWord;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      radioSync_q <= 2'b11;
      wireSync_q  <= 2'b11;
    end else begin
      radioSync_q <= {radioSync_q[0], ReceivedRadio};
      wireSync_q  <= {wireSync_q[0], ReceivedWire};
    end
  end

  SplitRadioReceiverLane #(.DATA_BITS(DATA_BITS), .BIT_CYCLES(BIT_CYCLES)) radioLane (
    .clock_i(Clock), .reset_i(Reset), .rx_i(radioSync_q[1]), .releaseLane_i(releaseRadio),
    .done_o(radioDone), .word_o(radioWord), .frameErr_o(radioErr)
  );

  SplitRadioReceiverLane #(.DATA_BITS(DATA_BITS), .BIT_CYCLES(BIT_CYCLES)) wireLane (
    .clock_i(Clock), .reset_i(Reset), .rx_i(wireSync_q[1]), .releaseLane_i(releaseWire),
    .done_o(wireDone), .word_o(wireWord), .frameErr_o(wireErr)
  );

  combState_t           comb_q;
  logic [SW-1:0]        skew_q;
  logic                 useRadio_q, useWire_q;
  logic [DATA_BITS-1:0] data_q;
  logic [1:0]           source_q;
  logic                 valid_q, mismatch_q, overrun_q;
  logic [DATA_BITS-1:0] emitWord_d;
  logic [1:0]           emitSource_d;
  logic                 emitMismatch_d, accept;

  always_comb begin
    emitWord_d     = radioWord;
    emitSource_d   = 2'b01;
    emitMismatch_d = 1'b0;
    if (useRadio_q && useWire_q) begin
      emitSource_d = 2'b11;
      if (radioWord != wireWord) begin
        emitMismatch_d = 1'b1;
        emitWord_d     = (PREFER_RADIO != 0) ? radioWord : wireWord;
      end
    end else if (useWire_q) begin
      emitWord_d   = wireWord;
      emitSource_d = 2'b10;
    end
  end

  assign accept       = valid_q && DataReady;
  assign releaseRadio = (comb_q == COMB_EMIT) && useRadio_q;
  assign releaseWire  = (comb_q == COMB_EMIT) && useWire_q;

  // An EMIT that finds the output register occupied and not draining is dropped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      comb_q     <= COMB_WAIT;
      skew_q     <= '0;
      useRadio_q <= 1'b0;
      useWire_q  <= 1'b0;
      data_q     <= '0;
      source_q   <= 2'b00;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      overrun_q  <= 1'b0;
      if (accept) valid_q <= 1'b0;
      case (comb_q)
        COMB_WAIT: begin
          skew_q     <= '0;
          useRadio_q <= radioDone;
          useWire_q  <= wireDone;
          if (radioDone && wireDone) comb_q <= COMB_EMIT;
          else if (radioDone || wireDone) comb_q <= COMB_PAIR;
        end
        COMB_PAIR: begin
          skew_q <= skew_q + 1'b1;
          if ((useRadio_q && wireDone) || (useWire_q && radioDone)) begin
            useRadio_q <= 1'b1;
            useWire_q  <= 1'b1;
            comb_q     <= COMB_EMIT;
          end else if (skew_q == SKEW_LAST) begin
            comb_q <= COMB_EMIT;
          end
        end
        COMB_EMIT: begin
          mismatch_q <= emitMismatch_d;
          if (!valid_q || accept) begin
            data_q   <= emitWord_d;
            source_q <= emitSource_d;
            valid_q  <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
          useRadio_q <= 1'b0;
          useWire_q  <= 1'b0;
          comb_q     <= COMB_WAIT;
        end
        default: comb_q <= COMB_WAIT;
      endcase
    end
  end

  assign Data       = data_q;
  assign DataValid  = valid_q;
  assign Source     = source_q;
  assign Mismatch   = mismatch_q;
  assign Overrun    = overrun_q;
  assign FrameError = {wireErr, radioErr};
endmodule

// File: tb/tb_split_radio_receiver.sv
// Directed bench for split_radio_receiver: serial frames on both lanes, a
// scoreboard of expected output words, and counters for the status pulses.

module tb_split_radio_receiver;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CYCLES = 16;
  localparam int SKEW_MAX   = 32;

  logic       Clock;
  logic       Reset;
  logic       ReceivedRadio;
  logic       ReceivedWire;
  logic [7:0] Data;
  logic       DataValid;
  logic       DataReady;
  logic [1:0] Source;
  logic       Mismatch;
  logic [1:0] FrameError;
  logic       Overrun;

  split_radio_receiver #(
    .DATA_BITS(DATA_BITS), .BIT_CYCLES(BIT_CYCLES), .SKEW_MAX(SKEW_MAX), .PREFER_RADIO(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ReceivedRadio(ReceivedRadio), .ReceivedWire(ReceivedWire),
    .Data(Data), .DataValid(DataValid), .DataReady(DataReady), .Source(Source),
    .Mismatch(Mismatch), .FrameError(FrameError), .Overrun(Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] source;
  } expect_t;

  expect_t expQ[$];
  int total = 0;
  int bad   = 0;
  int mismatchCnt, radioErrCnt, wireErrCnt, overrunCnt, acceptCnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [7:0] data, input logic [1:0] source);
    expect_t e;
    e.data   = data;
    e.source = source;
    expQ.push_back(e);
  endtask

  task automatic clearCounts();
    mismatchCnt = 0;
    radioErrCnt = 0;
    wireErrCnt  = 0;
    overrunCnt  = 0;
    acceptCnt   = 0;
  endtask

  // Each serial bit is held for BIT_CYCLES clocks, changed just after a rising edge.
  task automatic driveBit(input bit toRadio, input logic value);
    @(posedge Clock);
    #1;
    if (toRadio) ReceivedRadio = value;
    else         ReceivedWire  = value;
    repeat (BIT_CYCLES - 1) @(posedge Clock);
  endtask

  task automatic sendFrame(input bit toRadio, input logic [7:0] word, input logic stopBit, input int delayCycles);
    repeat (delayCycles) @(posedge Clock);
    driveBit(toRadio, 1'b0);
    for (int i = 0; i < DATA_BITS; i++) driveBit(toRadio, word[i]);
    driveBit(toRadio, stopBit);
    @(posedge Clock);
    #1;
    if (toRadio) ReceivedRadio = 1'b1;
    else         ReceivedWire  = 1'b1;
  endtask

  task automatic applyStimulus(input bit radioEn, input logic [7:0] radioWord, input logic radioStop,
                               input int radioDelay, input bit wireEn, input logic [7:0] wireWord,
                               input logic wireStop, input int wireDelay);
    fork
      if (radioEn) sendFrame(1'b1, radioWord, radioStop, radioDelay);
      if (wireEn)  sendFrame(1'b0, wireWord, wireStop, wireDelay);
    join
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((expQ.size() != 0 || DataValid) && n < 4000) begin
      @(negedge Clock);
      n++;
    end
    checkOutput({tag, "_drain"}, expQ.size(), 0);
    repeat (20) @(negedge Clock);
  endtask

  // Scoreboard side: every accepted word is matched against the oldest expectation.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (Mismatch) mismatchCnt++;
      if (FrameError[0]) radioErrCnt++;
      if (FrameError[1]) wireErrCnt++;
      if (Overrun) overrunCnt++;
      if (DataValid && DataReady) begin
        acceptCnt++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", expQ.size(), 1);
        end else begin
          expect_t e;
          e = expQ.pop_front();
          checkOutput("data", Data, e.data);
          checkOutput("source", Source, e.source);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int n;
    clearCounts();
    Reset         = 1'b1;
    ReceivedRadio = 1'b1;
    ReceivedWire  = 1'b1;
    DataReady     = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checkOutput("reset_data", Data, 0);
    checkOutput("reset_valid", DataValid, 0);
    checkOutput("reset_source", Source, 0);
    checkOutput("reset_mismatch", Mismatch, 0);
    checkOutput("reset_frameerror", FrameError, 0);
    checkOutput("reset_overrun", Overrun, 0);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    $display("[TB] aligned pair 0xA5");
    clearCounts();
    pushExpected(8'hA5, 2'b11);
    applyStimulus(1, 8'hA5, 1'b1, 0, 1, 8'hA5, 1'b1, 0);
    waitDrain("t1");
    checkOutput("t1_accepts", acceptCnt, 1);
    checkOutput("t1_mismatch", mismatchCnt, 0);

    $display("[TB] skewed mismatch 0x3C/0x3D");
    clearCounts();
    pushExpected(8'h3C, 2'b11);
    applyStimulus(1, 8'h3C, 1'b1, 0, 1, 8'h3D, 1'b1, 10);
    waitDrain("t2");
    checkOutput("t2_mismatch", mismatchCnt, 1);
    checkOutput("t2_accepts", acceptCnt, 1);

    $display("[TB] wire only 0x81");
    clearCounts();
    pushExpected(8'h81, 2'b10);
    n = 0;
    fork
      applyStimulus(0, 8'h00, 1'b1, 0, 1, 8'h81, 1'b1, 0);
      while (!DataValid && n < 1000) begin
        @(negedge Clock);
        n++;
      end
    join
    checkOutput("t3_latency_window", (n >= SKEW_MAX + 156 && n <= SKEW_MAX + 160), 1);
    waitDrain("t3");
    checkOutput("t3_mismatch", mismatchCnt, 0);

    $display("[TB] radio framing fault with wire 0x55");
    clearCounts();
    pushExpected(8'h55, 2'b10);
    applyStimulus(1, 8'h6B, 1'b0, 0, 1, 8'h55, 1'b1, 0);
    waitDrain("t4");
    checkOutput("t4_radio_err", radioErrCnt, 1);
    checkOutput("t4_wire_err", wireErrCnt, 0);

    clearCounts();
    @(posedge Clock);
    #1 ReceivedRadio = 1'b0;
    repeat (4) @(posedge Clock);
    #1 ReceivedRadio = 1'b1;
    repeat (300) @(negedge Clock);
    checkOutput("t4_glitch_accepts", acceptCnt, 0);
    checkOutput("t4_glitch_err", radioErrCnt, 0);
    checkOutput("t4_glitch_valid", DataValid, 0);

    $display("[TB] overrun with consumer stalled");
    clearCounts();
    DataReady = 1'b0;
    pushExpected(8'h11, 2'b11);
    applyStimulus(1, 8'h11, 1'b1, 0, 1, 8'h11, 1'b1, 0);
    n = 0;
    while (!DataValid && n < 100) begin
      @(negedge Clock);
      n++;
    end
    applyStimulus(1, 8'h22, 1'b1, 0, 1, 8'h22, 1'b1, 0);
    repeat (40) @(negedge Clock);
    checkOutput("t5_overrun", overrunCnt, 1);
    checkOutput("t5_held_data", Data, 8'h11);
    checkOutput("t5_held_valid", DataValid, 1);
    checkOutput("t5_held_source", Source, 2'b11);
    DataReady = 1'b1;
    waitDrain("t5");
    checkOutput("t5_accepts", acceptCnt, 1);

    $display("[TB] reset in the middle of a frame");
    clearCounts();
    fork
      applyStimulus(1, 8'hC3, 1'b1, 0, 1, 8'hC3, 1'b1, 0);
      begin
        repeat (60) @(posedge Clock);
        #1 Reset = 1'b1;
        repeat (140) @(posedge Clock);
        @(negedge Clock);
        checkOutput("t6_reset_valid", DataValid, 0);
        checkOutput("t6_reset_data", Data, 0);
        Reset = 1'b0;
      end
    join
    repeat (300) @(negedge Clock);
    checkOutput("t6_no_partial", acceptCnt, 0);
    pushExpected(8'h7E, 2'b11);
    applyStimulus(1, 8'h7E, 1'b1, 0, 1, 8'h7E, 1'b1, 0);
    waitDrain("t6");
    checkOutput("t6_accepts", acceptCnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
